// File: rtl/word_addr_reader_if.sv
// Request, memory and response signals for the byte-address to word-read converter.
interface word_addr_reader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic                mem_req;
  logic [ADDR_W-3:0]   mem_index;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;
  logic                busy;

  modport slave (
    input  req_valid, req_addr, mem_ack, mem_rdata, rsp_ready,
    output req_ready, mem_req, mem_index, rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_addr, mem_ack, mem_rdata, rsp_ready,
    input  req_ready, mem_req, mem_index, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/word_addr_reader.sv
// Converts a byte address to a word index, issues one memory read and returns
// the word (or an error for misalignment / timeout) over a valid/ready response.
module word_addr_reader #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input logic              clk,
  input logic              reset,
  word_addr_reader_if.slave bus
);
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [IDX_W-1:0]    mem_index_q, mem_index_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic misaligned;
  logic expired;

  assign misaligned = (bus.req_addr[1:0] != 2'b00);
  assign expired    = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_index_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_index_q <= mem_index_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = misaligned ? RESP : ISSUE;
      ISSUE:   if (bus.mem_ack || expired) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered output / datapath updates; ack takes priority over timeout
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_index_d = mem_index_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            mem_req_d   = 1'b1;
            mem_index_d = bus.req_addr[ADDR_W-1:2];
            cnt_d       = '0;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_ack) begin
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = bus.mem_rdata;
        end else if (expired) begin
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: begin
        mem_req_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_index = mem_index_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_word_addr_reader.sv
// Directed self-checking bench for word_addr_reader.
module tb_word_addr_reader;
  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  word_addr_reader_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  word_addr_reader #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rst_mem_req",   64'(bus.mem_req),   64'd0);
    check("rst_mem_index", 64'(bus.mem_index), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
    check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    tick();
    tick();
    reset = 1'b0;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Aligned read, immediate ack
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0010;
    tick();
    bus.req_valid = 1'b0;
    check("al_mem_req",   64'(bus.mem_req),   64'd1);
    check("al_mem_index", 64'(bus.mem_index), 64'h4);
    check("al_busy",      64'(bus.busy),      64'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack = 1'b0;
    check("al_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("al_rsp_data",  64'(bus.rsp_data),  64'hDEAD_BEEF);
    check("al_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("al_mem_req_off", 64'(bus.mem_req), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("al_done_valid", 64'(bus.rsp_valid), 64'd0);
    check("al_done_ready", 64'(bus.req_ready), 64'd1);

    // Misaligned address
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0013;
    tick();
    bus.req_valid = 1'b0;
    check("mis_mem_req",   64'(bus.mem_req),   64'd0);
    check("mis_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("mis_rsp_err",   64'(bus.rsp_err),   64'd1);
    check("mis_rsp_data",  64'(bus.rsp_data),  64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("mis_done_ready", 64'(bus.req_ready), 64'd1);
    check("mis_done_memreq", 64'(bus.mem_req), 64'd0);

    // Timeout: mem_req high for cycles 1..15, error response at cycle 16
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0100;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      check($sformatf("to_mem_req_c%0d", i), 64'(bus.mem_req), 64'd1);
      check($sformatf("to_mem_idx_c%0d", i), 64'(bus.mem_index), 64'h40);
      check($sformatf("to_no_rsp_c%0d", i), 64'(bus.rsp_valid), 64'd0);
      tick();
    end
    check("to_mem_req_off", 64'(bus.mem_req),   64'd0);
    check("to_rsp_valid",   64'(bus.rsp_valid), 64'd1);
    check("to_rsp_err",     64'(bus.rsp_err),   64'd1);
    check("to_rsp_data",    64'(bus.rsp_data),  64'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    tick();
    bus.mem_ack = 1'b0;
    check("to_late_err",   64'(bus.rsp_err),   64'd1);
    check("to_late_data",  64'(bus.rsp_data),  64'd0);
    check("to_late_valid", 64'(bus.rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("idle_ack_ready", 64'(bus.req_ready), 64'd1);
    check("idle_ack_valid", 64'(bus.rsp_valid), 64'd0);
    check("idle_ack_memrq", 64'(bus.mem_req),   64'd0);

    // Backpressure with a pending request held during the transaction
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0020;
    tick();
    bus.req_addr  = 32'h0000_0040;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i), 64'(bus.rsp_valid), 64'd1);
      check($sformatf("bp_data_%0d", i),  64'(bus.rsp_data),  64'h1234_5678);
      check($sformatf("bp_err_%0d", i),   64'(bus.rsp_err),   64'd0);
      check($sformatf("bp_ready_%0d", i), 64'(bus.req_ready), 64'd0);
      check($sformatf("bp_busy_%0d", i),  64'(bus.busy),      64'd1);
      check($sformatf("bp_memreq_%0d", i), 64'(bus.mem_req),  64'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp_hs_valid",  64'(bus.rsp_valid), 64'd0);
    check("bp_hs_ready",  64'(bus.req_ready), 64'd1);
    check("bp_hs_memreq", 64'(bus.mem_req),   64'd0);
    tick();
    bus.req_valid = 1'b0;
    check("bp_next_memreq", 64'(bus.mem_req),   64'd1);
    check("bp_next_index",  64'(bus.mem_index), 64'h10);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    bus.mem_ack = 1'b0;
    check("bp_next_data", 64'(bus.rsp_data), 64'h0BAD_F00D);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Reset mid-transaction takes effect without a clock edge
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0080;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("mr_pre_memreq", 64'(bus.mem_req), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_memreq",   64'(bus.mem_req),   64'd0);
    check("mr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mr_busy",     64'(bus.busy),      64'd0);
    tick();
    reset = 1'b0;
    check("mr_req_ready", 64'(bus.req_ready), 64'd1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("mr_late_ack_valid", 64'(bus.rsp_valid), 64'd0);
    check("mr_late_ack_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hFFFF_FFFC;
    tick();
    bus.req_valid = 1'b0;
    check("wrap_memreq", 64'(bus.mem_req),   64'd1);
    check("wrap_index",  64'(bus.mem_index), 64'h3FFF_FFFF);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5_0001;
    tick();
    bus.mem_ack = 1'b0;
    check("wrap_data", 64'(bus.rsp_data), 64'hA5A5_0001);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Ack coinciding with the final timeout cycle wins
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0200;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    check("co_memreq_c15", 64'(bus.mem_req),   64'd1);
    check("co_index",      64'(bus.mem_index), 64'h80);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_ack = 1'b0;
    check("co_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("co_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("co_rsp_data",  64'(bus.rsp_data),  64'hCAFE_F00D);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("co_done_ready", 64'(bus.req_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
